// File: rtl/cdma_despreader.sv
// rtl/cdma_despreader.sv - integrate-and-dump CDMA despreader with local PN regeneration
module cdma_despreader #(
    parameter int         SPREAD_LEN = 8,
    parameter int         ACC_W      = 16,
    parameter logic [5:0] PN_SEED    = 6'b101010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic             sync,
    input  logic [5:0]       user_code,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [ACC_W-1:0] corr_out,
    output logic             locked
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;
    localparam logic [5:0] LAST_CHIP = 6'(SPREAD_LEN - 1);

    function automatic logic [5:0] pn_next(input logic [5:0] p);
        return {p[4:0], p[5] ^ p[4]};
    endfunction

    logic [0:0]       state;
    logic [5:0]       pn;
    logic [5:0]       code_q;
    logic [5:0]       chip_cnt;
    logic [ACC_W-1:0] acc;

    logic             chip;
    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] product;
    logic [ACC_W-1:0] total;

    // On the sync sample the latched code and PN are not yet valid, so use the bypass values.
    always_comb begin
        sample_ext = {{(ACC_W-8){sample_in[7]}}, sample_in};
        chip       = sync ? ^(PN_SEED & user_code) : ^(pn & code_q);
        product    = chip ? (ACC_W'(0) - sample_ext) : sample_ext;
        total      = acc + product;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pn        <= PN_SEED;
            code_q    <= 6'd0;
            chip_cnt  <= 6'd0;
            acc       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            corr_out  <= '0;
            locked    <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (sample_valid) begin
                if (sync) begin
                    code_q   <= user_code;
                    pn       <= pn_next(PN_SEED);
                    acc      <= product;
                    chip_cnt <= 6'd1;
                    locked   <= 1'b1;
                    state    <= ACCUM;
                end else if (state == ACCUM) begin
                    pn <= pn_next(pn);
                    if (chip_cnt == LAST_CHIP) begin
                        corr_out  <= total;
                        bit_out   <= !total[ACC_W-1] && (total != '0);
                        bit_valid <= 1'b1;
                        acc       <= '0;
                        chip_cnt  <= 6'd0;
                    end else begin
                        acc      <= total;
                        chip_cnt <= chip_cnt + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/cdma_despreader.md
Name: cdma_despreader

Overview:
- Receive-side stage directly downstream of cdma_transmitter.
- Consumes the signed 8-bit BPSK chip stream (+100/-100 nominal) and regenerates the same 6-bit PN sequence locally.
- Multiplies each chip by the user-masked PN chip and integrates over SPREAD_LEN chips (integrate-and-dump).
- Emits one hard bit decision plus the raw correlation per symbol. One instance per user; user code selected at sync time.

Parameters:
- SPREAD_LEN, 8, chips per data bit; range 2..63.
- ACC_W, 16, accumulator/correlation width; must be >= 9 + clog2(SPREAD_LEN).
- PN_SEED, 6'b101010, LFSR load value on reset and sync; must equal the transmitter seed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- sample_in  in  8  signed chip sample.
- sample_valid  in  1  sample_in valid this cycle; chip accepted on rising clk when high.
- sync  in  1  symbol/PN alignment strobe; effective only together with sample_valid.
- user_code  in  6  spreading mask; latched only on an accepted sync.
- bit_out  out  1  hard decision for last completed symbol.
- bit_valid  out  1  one-cycle pulse: bit_out/corr_out updated.
- corr_out  out  ACC_W  signed correlation of last completed symbol.
- locked  out  1  high from first accepted sync until reset.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pn=PN_SEED; code_q=0; chip_cnt=0; acc=0.
  - bit_out=0, bit_valid=0, corr_out=0, locked=0.
- LFSR:
  - Identical to the transmitter: fb = pn[5]^pn[4]; next pn = {pn[4:0], fb}; period 63.
  - Advances only on accepted samples; holds while sample_valid=0.
- Local chip: chip = ^(pn & code_q). For the sync sample, use PN_SEED and user_code directly (the bypass value, not the latched one).
- Product: chip=1 -> -sample_in; chip=0 -> +sample_in. Sign-extend to ACC_W before negating, so -(-128)=+128 is exact. No saturation; the width rule guarantees no overflow.
- FSM states IDLE, ACCUM:
  - IDLE: samples without sync are ignored (pn, acc unchanged).
  - sample_valid & sync, in any state: latch code_q=user_code; pn <= next(PN_SEED); acc=product; chip_cnt=1; locked=1; state=ACCUM. Any partial symbol is discarded and no bit_valid is issued for it.
  - ACCUM, sample_valid & !sync, chip_cnt < SPREAD_LEN-1: acc += product; chip_cnt++.
  - ACCUM, sample_valid & !sync, chip_cnt == SPREAD_LEN-1 (final chip):
    - total = acc + product.
    - Next cycle: corr_out=total; bit_out = (total > 0); bit_valid=1.
    - Same edge: acc=0, chip_cnt=0, state stays ACCUM.
    - Back-to-back symbols with no gap are supported.
- Latency: bit_valid rises on the clock edge that accepts the last chip of a symbol, i.e. 1 cycle after that chip is presented.
- Ties: total == 0 -> bit_out=0.
- bit_valid is high for exactly one cycle per completed symbol. corr_out and bit_out hold between pulses.
- SPREAD_LEN=1 is unsupported.
- Gaps (sample_valid=0) mid-symbol: acc, chip_cnt and pn all hold; the result is identical to a gap-free stream.
- Reset mid-symbol discards everything and returns to IDLE with locked=0.

Test Plan:
- Reset value check: apply rst=0 for 5 cycles -> pn=101010, bit_out=0, bit_valid=0, corr_out=0, locked=0. Release reset and drive samples without sync -> no bit_valid, locked stays 0.
- Loopback data=1: transmitter model (seed 101010, code 101011, same LFSR), sync on first chip, SPREAD_LEN=8, data=1 -> bit_valid one cycle after chip 8, corr_out=+800, bit_out=1. Next symbol with data=0 back-to-back -> corr_out=-800, bit_out=0.
- Gaps in sample_valid: same stream as the loopback scenario with sample_valid=0 for 3 cycles after chips 2 and 5 -> identical corr_out/bit_out sequence, bit_valid count unchanged.
- Edge values: all samples 0 -> corr_out=0, bit_out=0. All samples -128 with chips arranged so every product is +128 -> corr_out=+1024 exactly, no wrap.
- Sync mid-symbol: sync after chip 4 of a symbol -> no bit_valid for the partial symbol. The next bit_valid occurs 8 accepted chips after the sync, and code_q takes the new user_code (110101): wrong-code data yields |corr_out| < 800.
- Async reset mid-symbol: pull rst low between clock edges after chip 5 -> outputs clear immediately without a clock edge, and no bit_valid appears after release until a new sync plus 8 chips.
